// File: rtl/fifo_pkt_pkg.sv
// Shared types and helpers for the FWFT-FIFO to AXI-Stream packetizer.
// The header-pack function is used only when PKT_HEADER_EN is defined.
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam int HDR_LEN_BITS  = 8;
    localparam int HDR_WORD_BITS = 64;

    // Header word: sequence number above the 8-bit payload length; callers truncate to their width.
    function automatic logic [HDR_WORD_BITS-1:0] pack_header(
        input logic [HDR_WORD_BITS-HDR_LEN_BITS-1:0] seq,
        input logic [HDR_LEN_BITS-1:0]               len
    );
        return {seq, len};
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream output stage: holds data/last while stalled, reloads when empty or accepted.
module axis_out_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic                  ld
);

    assign ld = !m_tvalid || m_tready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_tdata  <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (ld) begin
            if (load_en) begin
                m_tdata  <= load_data;
                m_tvalid <= 1'b1;
                m_tlast  <= load_last;
            end else begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fifo_axis_packetizer.sv
// Pops a FWFT FIFO and emits fixed-length AXI-Stream packets with tlast and a packet counter.
// Optional macro PKT_HEADER_EN prepends a {seq, PKT_LEN} header beat to each packet.
module fifo_axis_packetizer
    import fifo_pkt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic                  busy
);

    localparam logic [HDR_LEN_BITS-1:0] LAST_BEAT = HDR_LEN_BITS'(PKT_LEN - 1);

    state_t                  state, state_next;
    logic [HDR_LEN_BITS-1:0] beat_cnt;
    logic                    ld, pop, load_en, load_last, beat_last, xfer;
    logic [DATA_WIDTH-1:0]   load_data;

    assign beat_last  = (beat_cnt == LAST_BEAT);
    assign xfer       = m_tvalid && m_tready;
    assign fifo_rd_en = pop;

`ifdef PKT_HEADER_EN
    localparam logic [HDR_LEN_BITS-1:0] HDR_LEN = HDR_LEN_BITS'(PKT_LEN);

    logic [DATA_WIDTH-HDR_LEN_BITS-1:0] seq;
    logic [DATA_WIDTH-1:0]              hdr_word;

    assign hdr_word = DATA_WIDTH'(pack_header((HDR_WORD_BITS-HDR_LEN_BITS)'(seq), HDR_LEN));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                        seq <= '0;
        else if (state == HDR && load_en) seq <= seq + 1'b1;
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_en    = 1'b0;
        load_data  = fifo_dout;
        load_last  = beat_last;
        case (state)
`ifdef PKT_HEADER_EN
            IDLE: if (!fifo_empty && ld) state_next = HDR;
            HDR: begin
                if (!fifo_empty && ld) begin
                    load_en    = 1'b1;
                    load_data  = hdr_word;
                    load_last  = 1'b0;
                    state_next = PAYLOAD;
                end
            end
`else
            IDLE: if (!fifo_empty && ld) state_next = PAYLOAD;
`endif
            PAYLOAD: begin
                if (!fifo_empty && ld) begin
                    pop     = 1'b1;
                    load_en = 1'b1;
                    if (beat_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            pkt_count <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            if (pop) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
            // Packet is counted when its tlast beat leaves, not when it is popped.
            if (xfer && m_tlast) pkt_count <= pkt_count + 1'b1;
            if (pop && beat_cnt == '0)  busy <= 1'b1;
            else if (xfer && m_tlast)   busy <= 1'b0;
        end
    end

    axis_out_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out (
        .clock    (clock),
        .reset    (reset),
        .load_en  (load_en),
        .load_data(load_data),
        .load_last(load_last),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .ld       (ld)
    );

endmodule
